// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus one memory-mapped toggle register,
// one outstanding request, configurable read latency. Define DMEM_BUS_ERR_EN for bus errors.
module dmem_responder #(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] TOGGLE_ADDR  = 32'd52
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] toggle_value
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  rsp_t        pend_q, pend_d;
  rsp_t        rsp_q, rsp_d;
  logic [31:0] tog_q, tog_d;
  logic [31:0] ram_q [DEPTH_WORDS];

  logic          accept, is_tog, bad, wr_ram, wr_tog;
  logic [AW-1:0] widx;
  logic [31:0]   lane_mask;
  rsp_t          cap;

  assign widx   = req_addr[AW+1:2];
  assign is_tog = (req_addr == TOGGLE_ADDR);

`ifdef DMEM_BUS_ERR_EN
  assign bad = (req_addr[1:0] != 2'b00) ||
               (!is_tog && (req_addr >= 32'(4 * DEPTH_WORDS)));
`else
  assign bad = 1'b0;
`endif

  assign accept = req_valid & req_ready;
  assign wr_tog = accept & req_we & is_tog & ~bad;
  assign wr_ram = accept & req_we & ~is_tog & ~bad;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign lane_mask[8*g +: 8] = {8{req_be[g]}};
    end
  endgenerate

  assign tog_d = wr_tog ? ((tog_q & ~lane_mask) | (req_wdata & lane_mask)) : tog_q;

  // Response payload is fixed at the accept edge; stores and errored accesses return zero.
  always_comb begin
    cap.err  = bad;
    cap.data = '0;
    if (!bad && !req_we)
      cap.data = is_tog ? tog_q : ram_q[widx];
  end

  always_ff @(posedge clk) begin
    if (wr_ram)
      for (int b = 0; b < 4; b++)
        if (req_be[b]) ram_q[widx][8*b +: 8] <= req_wdata[8*b +: 8];
  end

  // cnt counts down to zero on the edge that enters RESP, giving READ_LATENCY cycles accept->rsp.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_we || READ_LATENCY == 1) begin
            state_d = RESP;
            rsp_d   = cap;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            pend_d  = cap;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RESP;
          rsp_d   = pend_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      rsp_q   <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rsp_q   <= rsp_d;
      tog_q   <= tog_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rsp_q.data;
  assign rsp_err      = rsp_q.err;
  assign toggle_value = tog_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard queue of expected responses checked by a monitor.
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;
`ifdef DMEM_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, toggle_value;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .TOGGLE_ADDR(32'd52)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .toggle_value(toggle_value)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   nvec = 0, nerr = 0;
  exp_t mon_e;
  int   mon_a;

  logic [31:0] s_addr [3] = '{32'h10, 32'h20, 32'h34};
  logic [31:0] s_data [3] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h0000FF01};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && rsp_valid) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0 && acc_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        chk({mon_e.tag, "_rdata"}, rsp_rdata, mon_e.data);
        chk({mon_e.tag, "_err"}, 32'(rsp_err), 32'(mon_e.err));
        chk({mon_e.tag, "_lat"}, 32'(cyc - mon_a + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    if (req_ready) begin
      exp_q.push_back('{tag, exp_data, exp_err, we ? 1 : LAT});
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
    end
    req_valid = 1'b0;
    drain(tag);
  endtask

  initial begin
    int k, n, pulses;
    int acc [3];

    // Reset state
    #3 resetn = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_toggle", toggle_value, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Store then load
    xfer("st10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("ld10", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte enables
    xfer("st20", 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
    xfer("st20be", 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0);
    xfer("ld20", 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0);
    xfer("st_be0", 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0);
    xfer("ld20b", 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0);

    // Toggle register; 0x434 aliases RAM word 13 only when address wrap is in effect
    xfer("st_w13", 1'b1, 4'hF, 32'h434, 32'h5555AAAA, 32'h0, ERR_EN);
    xfer("st_tog", 1'b1, 4'hF, 32'h34, 32'h1, 32'h0, 1'b0);
    chk("tog_after_st", toggle_value, 32'h1);
    xfer("ld_tog", 1'b0, 4'hF, 32'h34, 32'h0, 32'h1, 1'b0);
    xfer("ld_w13", 1'b0, 4'hF, 32'h434, 32'h0, ERR_EN ? 32'h0 : 32'h5555AAAA, ERR_EN);
    xfer("st_tog_be", 1'b1, 4'b0010, 32'h34, 32'hFFFFFF00, 32'h0, 1'b0);
    chk("tog_be", toggle_value, 32'h0000FF01);

    // Back-to-back loads with req_valid held high
    k = 0; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = s_addr[0];
    while (k < 3 && n < 40) begin
      if (req_ready) begin
        exp_q.push_back('{"stream", s_data[k], 1'b0, LAT});
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        acc[k] = cyc;
        k++;
        if (k < 3) req_addr = s_addr[k];
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("stream_accepts", 32'(k), 32'd3);
    chk("stream_gap01", 32'(acc[1] - acc[0]), 32'(LAT + 1));
    chk("stream_gap12", 32'(acc[2] - acc[1]), 32'(LAT + 1));
    drain("stream");

    // Reset while a load is waiting: response dropped
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_toggle", toggle_value, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    chk("midrst_ready_after", 32'(req_ready), 32'd1);

    // Reset during a store ack: the store stays committed
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h40; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    xfer("ld40", 1'b0, 4'hF, 32'h40, 32'h0, 32'h77, 1'b0);
    xfer("ld20_post_rst", 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0);

    // Misaligned / out-of-range handling
    xfer("st0", 1'b1, 4'hF, 32'h0, 32'h12345678, 32'h0, 1'b0);
    xfer("ld402", 1'b0, 4'hF, 32'h402, 32'h0, ERR_EN ? 32'h0 : 32'h12345678, ERR_EN);
    xfer("st400", 1'b1, 4'hF, 32'h400, 32'h99, 32'h0, ERR_EN);
    xfer("ld0", 1'b0, 4'hF, 32'h0, 32'h0, ERR_EN ? 32'h12345678 : 32'h99, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
